dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
//   Data-memory responder answering the MEM stage's MemRead/MemWrite requests.
//   Models a slow memory with a configurable number of wait states.
//   Raises busy so the hazard logic freezes PC, IF/ID, ID/EX and EX/MEM while a request is open.
//   Sits between MEM_STAGE (initiator) and the word-addressed storage array.
// PARAMETERS
//   DATA_W       32  data word width
//   ADDR_W       8   word-address bits; depth = 2**ADDR_W words
//   WAIT_STATES  2   extra stall cycles per access; legal range 0..15
// PORTS
//   CLK        in   1       single clock, rising edge
//   RST        in   1       synchronous, active-high reset
//   MemRead    in   1       read request from EX/MEM register
//   MemWrite   in   1       write request from EX/MEM register
//   address    in   32      byte address (ALU result)
//   writeData  in   DATA_W  store data
//   readData   out  DATA_W  load data, registered
//   busy       out  1       stall request to pipeline, combinational
//   done       out  1       one-cycle completion pulse, registered
//   misaligned out  1       sticky error: address[1:0] != 0 seen
// BEHAVIOUR
//   Reset
//     On RST at a clock edge: state=IDLE, cnt=0, readData=0, done=0, misaligned=0.
//     A pending access is dropped and its write is never performed.
//     Array contents are NOT reset.
//   FSM states: IDLE, WAIT, RESP.
//     IDLE
//       req = MemRead|MemWrite; busy=req.
//       On req: latch op, word index address[ADDR_W+1:2], writeData, misaligned bit; cnt<=WAIT_STATES.
//       Next state is WAIT if WAIT_STATES>0, else RESP.
//     WAIT
//       busy=1; cnt decrements each cycle; inputs are ignored.
//       When cnt==1, go to RESP.
//     Entering RESP (edge)
//       Latched write: array[idx]<=data.
//       Latched read: readData<=array[idx] (old contents).
//       done<=1.
//     RESP
//       busy=0, done=1; the pipeline advances at the end of this cycle.
//       Inputs are ignored (same instruction still present); next state IDLE.
//   Latency: stall cycles = WAIT_STATES+1; readData is valid in the RESP cycle.
//     readData holds its value until the next read completes.
//   Back-to-back accesses: IDLE after RESP re-samples; minimum period = WAIT_STATES+2 cycles.
//   Address wrap: bits above ADDR_W+1 are ignored (modulo depth).
//   Misaligned (address[1:0]!=0)
//     Goes through the full FSM sequence; write suppressed; read returns 0.
//     misaligned<=1 at accept and stays set until RST.
//   MemRead&MemWrite together: treated as a write; readData is unchanged.
//   No request in IDLE: busy=0, done=0, no array access.
// STRUCTURE
//   mem_defs.vh (shared include)
//     State encodings ST_IDLE=2'd0, ST_WAIT=2'd1, ST_RESP=2'd2.
//     Op constants OP_RD, OP_WR; default DATA_W/ADDR_W.
//   Sub-module sync_ram
//     Single-port synchronous RAM, write-enable, registered read, no reset; instantiated once.
//   Top level holds the FSM, the wait counter and the request latch.
// TESTING
//   1 Write then read, WAIT_STATES=2
//     SW 0xDEADBEEF @0x10 -> busy high 3 cycles, done once.
//     LW @0x10 -> readData=0xDEADBEEF in the done cycle.
//   2 Zero wait states, WAIT_STATES=0
//     LW -> busy 1 cycle; done and valid readData the next cycle; period 2 cycles.
//   3 Misaligned
//     SW 0x1 @0x12 -> misaligned=1, array[4] unchanged.
//     LW @0x13 -> readData=0; flag stays 1 until RST.
//   4 Reset mid-operation
//     SW 0x55 @0x20, RST asserted in WAIT -> state IDLE, done never pulses.
//     Following LW @0x20 returns the prior contents.
//   5 Wrap, ADDR_W=8
//     SW 0xA5A5 @0x400 then LW @0x000 -> readData=0xA5A5.
//   6 Read+write together
//     MemRead=MemWrite=1, data 0x77 @0x8 -> array[2]=0x77, readData keeps its previous value.

Source files
------------

// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: FSM state and latched-op encodings
// plus the default geometry.
package dmem_responder_pkg;

    localparam int unsigned DefDataW = 32;
    localparam int unsigned DefAddrW = 8;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StResp = 2'd2
    } state_e;

    typedef enum logic {
        OpRd = 1'b0,
        OpWr = 1'b1
    } op_e;

endpackage

// File: rtl/dmem_responder_sync_ram.sv
// Single-port synchronous RAM with write enable and an enable-gated registered read.
// Contents and read register are not reset.
module dmem_responder_sync_ram #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 8
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one MEM-stage load/store, inserts WAIT_STATES stall cycles,
// then completes with a one-cycle done pulse. busy freezes the pipeline while a request is open.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int unsigned DATA_W      = DefDataW,
    parameter int unsigned ADDR_W      = DefAddrW,
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [31:0]       address,
    input  logic [DATA_W-1:0] writeData,
    output logic [DATA_W-1:0] readData,
    output logic              busy,
    output logic              done,
    output logic              misaligned
);

    localparam logic [3:0] WaitCnt = 4'(WAIT_STATES);
    localparam bit         NoWait  = (WAIT_STATES == 0);

    state_e            r_state;
    logic [3:0]        r_cnt;
    op_e               r_op;
    logic [ADDR_W-1:0] r_idx;
    logic [DATA_W-1:0] r_wdata;
    logic              r_mis;
    logic              r_done;
    logic              r_misaligned;
    logic              r_rd_zero;

    logic              w_req;
    logic              w_in_mis;
    logic              w_cur_wr;
    logic              w_cur_mis;
    logic [ADDR_W-1:0] w_cur_idx;
    logic [DATA_W-1:0] w_cur_wdata;
    logic              w_fire;
    logic              w_ram_we;
    logic              w_ram_re;
    logic [DATA_W-1:0] w_ram_rdata;
    logic              w_unused;

    assign w_req    = MemRead | MemWrite;
    assign w_in_mis = |address[1:0];
    assign w_unused = ^address[31:ADDR_W+2];

    // With zero wait states the access completes straight out of IDLE, so the RAM must see the
    // live request rather than the latch.
    always_comb begin
        w_cur_wr    = (r_op == OpWr);
        w_cur_mis   = r_mis;
        w_cur_idx   = r_idx;
        w_cur_wdata = r_wdata;
        if (r_state == StIdle) begin
            w_cur_wr    = MemWrite;
            w_cur_mis   = w_in_mis;
            w_cur_idx   = address[ADDR_W+1:2];
            w_cur_wdata = writeData;
        end
    end

    assign w_fire = !RST && (((r_state == StIdle) && w_req && NoWait) ||
                             ((r_state == StWait) && (r_cnt == 4'd1)));
    assign w_ram_we = w_fire && w_cur_wr && !w_cur_mis;
    assign w_ram_re = w_fire && !w_cur_wr && !w_cur_mis;

    dmem_responder_sync_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .i_clk   (CLK),
        .i_we    (w_ram_we),
        .i_re    (w_ram_re),
        .i_addr  (w_cur_idx),
        .i_wdata (w_cur_wdata),
        .o_rdata (w_ram_rdata)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state      <= StIdle;
            r_cnt        <= 4'd0;
            r_op         <= OpRd;
            r_idx        <= '0;
            r_wdata      <= '0;
            r_mis        <= 1'b0;
            r_done       <= 1'b0;
            r_misaligned <= 1'b0;
            r_rd_zero    <= 1'b1;
        end else begin
            r_done <= w_fire;
            // Completed loads own readData; a misaligned load forces it to zero.
            if (w_fire && !w_cur_wr) begin
                r_rd_zero <= w_cur_mis;
            end
            unique case (r_state)
                StIdle: begin
                    if (w_req) begin
                        r_op    <= MemWrite ? OpWr : OpRd;
                        r_idx   <= address[ADDR_W+1:2];
                        r_wdata <= writeData;
                        r_mis   <= w_in_mis;
                        r_cnt   <= WaitCnt;
                        r_state <= NoWait ? StResp : StWait;
                        if (w_in_mis) begin
                            r_misaligned <= 1'b1;
                        end
                    end
                end
                StWait: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        r_state <= StResp;
                    end
                end
                StResp: begin
                    r_state <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    always_comb begin
        busy = 1'b0;
        unique case (r_state)
            StIdle:  busy = w_req;
            StWait:  busy = 1'b1;
            default: busy = 1'b0;
        endcase
    end

    assign readData   = r_rd_zero ? '0 : w_ram_rdata;
    assign done       = r_done;
    assign misaligned = r_misaligned;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance with two wait states, one with none.
module tb_dmem_responder;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        rd2 = 1'b0, wr2 = 1'b0, rd0 = 1'b0, wr0 = 1'b0;
    logic [31:0] addr2 = '0, wd2 = '0, addr0 = '0, wd0 = '0;
    logic [31:0] rdo2, rdo0, got;
    logic        busy2, done2, mis2, busy0, done0, mis0;
    int          checks = 0;
    int          failures = 0;

    always #5 CLK = ~CLK;

    dmem_responder #(.DATA_W(32), .ADDR_W(8), .WAIT_STATES(2)) u_dut2 (
        .CLK(CLK), .RST(RST), .MemRead(rd2), .MemWrite(wr2), .address(addr2),
        .writeData(wd2), .readData(rdo2), .busy(busy2), .done(done2), .misaligned(mis2)
    );

    dmem_responder #(.DATA_W(32), .ADDR_W(8), .WAIT_STATES(0)) u_dut0 (
        .CLK(CLK), .RST(RST), .MemRead(rd0), .MemWrite(wr0), .address(addr0),
        .writeData(wd0), .readData(rdo0), .busy(busy0), .done(done0), .misaligned(mis0)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one access on the selected DUT and follow it to its done cycle.
    task automatic acc(input bit sel, input logic rd, input logic wr, input logic [31:0] a,
                       input logic [31:0] d, input int exp_busy, input string tag,
                       output logic [31:0] rdata);
        int nb;
        bit seen;
        @(negedge CLK);
        #1;
        chk({tag, ":idle_done"}, {31'b0, sel ? done0 : done2}, 32'd0);
        if (sel) begin rd0 = rd; wr0 = wr; addr0 = a; wd0 = d; end
        else     begin rd2 = rd; wr2 = wr; addr2 = a; wd2 = d; end
        nb = 0;
        seen = 1'b0;
        rdata = '0;
        for (int i = 0; i < 20 && !seen; i++) begin
            #1;
            if (sel ? done0 : done2) begin
                seen = 1'b1;
                rdata = sel ? rdo0 : rdo2;
            end else begin
                if (sel ? busy0 : busy2) nb++;
                @(negedge CLK);
            end
        end
        if (sel) begin rd0 = 1'b0; wr0 = 1'b0; end
        else     begin rd2 = 1'b0; wr2 = 1'b0; end
        chk({tag, ":done_seen"}, {31'b0, seen}, 32'd1);
        chk({tag, ":busy_cycles"}, nb, exp_busy);
    endtask

    initial begin
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        #1;
        chk("rst_rd2", rdo2, 32'h0);
        chk("rst_busy2", {31'b0, busy2}, 32'd0);
        chk("rst_done2", {31'b0, done2}, 32'd0);
        chk("rst_mis2", {31'b0, mis2}, 32'd0);
        chk("rst_rd0", rdo0, 32'h0);

        // Write then read with two wait states
        acc(1'b0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 3, "t1_sw", got);
        acc(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 3, "t1_lw", got);
        chk("t1_lw_data", got, 32'hDEADBEEF);

        // Zero wait states, back-to-back at a two-cycle period
        acc(1'b1, 1'b0, 1'b1, 32'h4, 32'h12345678, 1, "t2_sw", got);
        acc(1'b1, 1'b1, 1'b0, 32'h4, 32'h0, 1, "t2_lw", got);
        chk("t2_lw_data", got, 32'h12345678);
        acc(1'b1, 1'b0, 1'b1, 32'h8, 32'h0BADF00D, 1, "t2_sw2", got);
        acc(1'b1, 1'b1, 1'b0, 32'h8, 32'h0, 1, "t2_lw2", got);
        chk("t2_lw2_data", got, 32'h0BADF00D);

        // Misaligned store is suppressed, misaligned load returns zero
        acc(1'b0, 1'b0, 1'b1, 32'h12, 32'h1, 3, "t3_sw", got);
        chk("t3_mis_set", {31'b0, mis2}, 32'd1);
        acc(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 3, "t3_lw_al", got);
        chk("t3_word4_kept", got, 32'hDEADBEEF);
        acc(1'b0, 1'b1, 1'b0, 32'h13, 32'h0, 3, "t3_lw_mis", got);
        chk("t3_lw_mis_data", got, 32'h0);
        acc(1'b0, 0, 1'b1, 32'h20, 32'hCAFE0020, 3, "t4_pre_sw", got);
        chk("t3_mis_sticky", {31'b0, mis2}, 32'd1);

        // Reset at the last wait cycle drops the pending store
        @(negedge CLK);
        wr2 = 1'b1; addr2 = 32'h20; wd2 = 32'h55;
        @(negedge CLK);
        wr2 = 1'b0;
        @(negedge CLK);
        #1;
        chk("t4_busy_in_wait", {31'b0, busy2}, 32'd1);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        #1;
        chk("t4_busy_after_rst", {31'b0, busy2}, 32'd0);
        chk("t4_mis_cleared", {31'b0, mis2}, 32'd0);
        chk("t4_rd_cleared", rdo2, 32'h0);
        for (int i = 0; i < 4; i++) begin
            chk("t4_no_done", {31'b0, done2}, 32'd0);
            @(negedge CLK);
            #1;
        end
        acc(1'b0, 1'b1, 1'b0, 32'h20, 32'h0, 3, "t4_lw", got);
        chk("t4_prior_data", got, 32'hCAFE0020);

        // Address wrap modulo depth
        acc(1'b0, 1'b0, 1'b1, 32'h400, 32'hA5A5, 3, "t5_sw", got);
        acc(1'b0, 1'b1, 1'b0, 32'h000, 32'h0, 3, "t5_lw", got);
        chk("t5_wrap_data", got, 32'hA5A5);

        // Read+write together acts as a write and leaves readData alone
        acc(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 3, "t6_pre_lw", got);
        acc(1'b0, 1'b1, 1'b1, 32'h8, 32'h77, 3, "t6_rw", got);
        chk("t6_rd_held", got, 32'hDEADBEEF);
        acc(1'b0, 1'b1, 1'b0, 32'h8, 32'h0, 3, "t6_lw", got);
        chk("t6_word2", got, 32'h77);
        chk("t6_mis_clear", {31'b0, mis2}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
